// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache sitting
// between the MEM-stage data port and next-level memory. Misses stall the
// pipeline while the victim line is written back (if dirty) and the new line
// is refilled one word per mem_ready beat.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss/writeback
// counters on extra output ports.
module l1_dcache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int ADDR_BITS   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_byte_en,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_writebacks
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                 state_q;
  logic [OFFSET_BITS-1:0] cnt_q;
  logic [OFFSET_BITS-1:0] cnt_nxt;

  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [LINES*WORDS];

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_word;
  logic                   unused_addr_bits;

  logic req, idle, hit, miss_start, write_hit, victim_dirty;
  logic beat, wb_last, rf_beat, rf_last;

  // The pipeline holds the request stable while stalled, so the live address
  // fields are used throughout the miss sequence.
  assign req_tag          = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
  assign req_idx          = cpu_addr[INDEX_BITS+OFFSET_BITS+1 : OFFSET_BITS+2];
  assign req_word         = cpu_addr[OFFSET_BITS+1 : 2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req          = cpu_read | cpu_write;
  assign idle         = (state_q == IDLE);
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_start   = idle && req && !hit;
  assign write_hit    = idle && cpu_write && hit;
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

  // mem_ready only counts while a beat is actually being requested.
  assign beat    = mem_req && mem_ready;
  assign cnt_nxt = cnt_q + 1'b1;
  assign wb_last = (state_q == WRITEBACK) && beat && (cnt_q == '1);
  assign rf_beat = (state_q == REFILL) && beat;
  assign rf_last = rf_beat && (cnt_q == '1);

  // CPU-facing outputs: stall on any miss or burst, loads read straight from the array.
  always_comb begin
    cpu_stall = !idle || (req && !hit);
    cpu_rdata = 32'd0;
    if (idle && cpu_read && !cpu_write && hit)
      cpu_rdata = data_q[{req_idx, req_word}];
  end

  // Miss-handling FSM with registered next-level memory beat outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            cnt_q   <= '0;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              state_q   <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
              mem_wdata <= data_q[{req_idx, {OFFSET_BITS{1'b0}}}];
            end else begin
              state_q  <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (beat) begin
            if (cnt_q == '1) begin
              state_q  <= REFILL;
              cnt_q    <= '0;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
            end else begin
              cnt_q     <= cnt_nxt;
              mem_addr  <= {tag_q[req_idx], req_idx, cnt_nxt, 2'b00};
              mem_wdata <= data_q[{req_idx, cnt_nxt}];
            end
          end
        end
        REFILL: begin
          if (beat) begin
            if (cnt_q == '1) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              mem_req <= 1'b0;
            end else begin
              cnt_q    <= cnt_nxt;
              mem_addr <= {req_tag, req_idx, cnt_nxt, 2'b00};
            end
          end
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Line status bits: only these are cleared by reset; contents survive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (write_hit)
        dirty_q[req_idx] <= 1'b1;
      if (wb_last)
        dirty_q[req_idx] <= 1'b0;
      if (rf_last) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: refill beats and byte-masked store hits.
  always_ff @(posedge clock) begin
    if (rf_beat)
      data_q[{req_idx, cnt_q}] <= mem_rdata;
    if (rf_last)
      tag_q[req_idx] <= req_tag;
    if (write_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_byte_en[b])
          data_q[{req_idx, req_word}][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // retry_q marks a request that missed, so its post-refill hit is not counted.
  logic retry_q;

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retry_q         <= 1'b0;
      stat_hits       <= 32'd0;
      stat_misses     <= 32'd0;
      stat_writebacks <= 32'd0;
    end else begin
      if (idle && req && hit) begin
        retry_q <= 1'b0;
        if (!retry_q)
          stat_hits <= sat_inc(stat_hits);
      end
      if (miss_start) begin
        retry_q     <= 1'b1;
        stat_misses <= sat_inc(stat_misses);
        if (victim_dirty)
          stat_writebacks <= sat_inc(stat_writebacks);
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Testbench for l1_dcache: directed load/store sequences against a flat
// CPU-view memory model plus a backing-memory responder with a configurable
// mem_ready gap.
module tb_l1_dcache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [3:0]  cpu_byte_en = 4'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  l1_dcache #(.INDEX_BITS(4), .OFFSET_BITS(2), .ADDR_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] backing[logic [31:0]];
  logic [31:0] ref_over[logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          gap = 1;
  int          wcnt = 0;
  bit          hold_v = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CPU-visible contents: latest store, else backing memory, else the fill pattern.
  function automatic logic [31:0] view(input logic [31:0] a);
    if (ref_over.exists(a)) return ref_over[a];
    if (backing.exists(a)) return backing[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Per-cycle comparison against the CPU-view model, then mem_ready/mem_rdata drive.
  always @(negedge clock) begin
    if (!reset) begin
      ref_over.delete();
      hold_v    = 1'b0;
      wcnt      = 0;
      mem_ready = 1'b0;
    end else begin
      if (!(cpu_read || cpu_write))
        chk("idle_no_stall", 32'(cpu_stall), 32'd0);
      if (cpu_read && !cpu_write && !cpu_stall)
        chk("load_data", cpu_rdata, view({cpu_addr[31:2], 2'b00}));
      if (cpu_write && !cpu_stall) begin
        logic [31:0] w;
        w = view({cpu_addr[31:2], 2'b00});
        for (int b = 0; b < 4; b++)
          if (cpu_byte_en[b]) w[8*b +: 8] = cpu_wdata[8*b +: 8];
        ref_over[{cpu_addr[31:2], 2'b00}] = w;
      end
      if (mem_req)
        chk("beat_addr_aligned", 32'(mem_addr[1:0]), 32'd0);
      if (mem_req && mem_we)
        chk("writeback_data", mem_wdata, view(mem_addr));
      if (mem_req && !mem_we)
        chk("refill_line", {4'd0, mem_addr[31:4]}, {4'd0, cpu_addr[31:4]});
      if (hold_v && mem_req) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", 32'(mem_we), 32'(prev_we));
      end
      if (mem_req) begin
        wcnt++;
        mem_ready = (wcnt >= gap);
        if (mem_ready) wcnt = 0;
      end else begin
        wcnt      = 0;
        mem_ready = 1'b0;
      end
      mem_rdata = view(mem_addr);
      hold_v    = mem_req && !mem_ready;
      prev_addr = mem_addr;
      prev_we   = mem_we;
    end
  end

  // Backing memory: log every completed beat and commit write beats.
  always @(posedge clock) begin
    if (reset && mem_req && mem_ready) begin
      beats.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (mem_we) backing[mem_addr] = mem_wdata;
    end
  end

  task automatic run_req(input bit wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int stalls, output logic [31:0] rdata);
    bit done;
    @(posedge clock); #1;
    beats.delete();
    cpu_read    = !wr || both;
    cpu_write   = wr;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    cpu_byte_en = be;
    stalls = 0;
    rdata  = 32'd0;
    done   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) chk("request_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic chk_beats(input string name, input bit we, input logic [31:0] base,
                           input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (first + i < beats.size()) begin
        chk({name, "_addr"}, beats[first+i].addr, base + 32'(4*i));
        chk({name, "_we"}, 32'(beats[first+i].we), 32'(we));
      end else begin
        chk({name, "_missing"}, 32'(beats.size()), 32'(first + i + 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    bit          found;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Cold load: clean miss, 4 refill beats
    gap = 1;
    run_req(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'd0, st, rd);
    chk("cold_stall", 32'(st), 32'd5);
    chk("cold_rdata", rd, 32'hA5A5_A5E5);
    chk("cold_nbeats", 32'(beats.size()), 32'd4);
    chk_beats("cold_rd", 1'b0, 32'h40, 0, 4);

    // Hit in the freshly filled line
    run_req(1'b0, 1'b0, 32'h0000_0044, 32'd0, 4'd0, st, rd);
    chk("hit_stall", 32'(st), 32'd0);
    chk("hit_rdata", rd, 32'hA5A5_A5E1);
    chk("hit_nbeats", 32'(beats.size()), 32'd0);

    // Store hit with partial byte enables, then read back
    run_req(1'b1, 1'b0, 32'h0000_0048, 32'h1122_3344, 4'b0011, st, rd);
    chk("st_stall", 32'(st), 32'd0);
    chk("st_nbeats", 32'(beats.size()), 32'd0);
    run_req(1'b0, 1'b0, 32'h0000_0048, 32'd0, 4'd0, st, rd);
    chk("st_load_rdata", rd, 32'hA5A5_3344);
    chk("st_load_nbeats", 32'(beats.size()), 32'd0);

    // Conflict miss on a dirty line: writeback then refill
    run_req(1'b0, 1'b0, 32'h0000_0448, 32'd0, 4'd0, st, rd);
    chk("dirty_stall", 32'(st), 32'd9);
    chk("dirty_rdata", rd, 32'hA5A5_A1ED);
    chk("dirty_nbeats", 32'(beats.size()), 32'd8);
    chk_beats("dirty_wb", 1'b1, 32'h40, 0, 4);
    chk_beats("dirty_rf", 1'b0, 32'h440, 4, 4);
    if (beats.size() == 8) begin
      chk("dirty_wb_word0", beats[0].data, 32'hA5A5_A5E5);
      chk("dirty_wb_word2", beats[2].data, 32'hA5A5_3344);
    end else begin
      chk("dirty_wb_count", 32'(beats.size()), 32'd8);
    end

    // Slow memory: a beat every 3rd cycle, clean victim
    gap = 3;
    run_req(1'b0, 1'b0, 32'h0000_0840, 32'd0, 4'd0, st, rd);
    chk("slow_stall", 32'(st), 32'd13);
    chk("slow_rdata", rd, 32'hA5A5_ADE5);
    chk("slow_nbeats", 32'(beats.size()), 32'd4);
    chk_beats("slow_rd", 1'b0, 32'h840, 0, 4);
    gap = 1;

    // Written-back store data comes back from memory
    run_req(1'b0, 1'b0, 32'h0000_0048, 32'd0, 4'd0, st, rd);
    chk("reload_stall", 32'(st), 32'd5);
    chk("reload_rdata", rd, 32'hA5A5_3344);

    // Read and write together behave as a store
    run_req(1'b1, 1'b1, 32'h0000_0044, 32'hAABB_0000, 4'b1100, st, rd);
    chk("rw_stall", 32'(st), 32'd0);
    chk("rw_nbeats", 32'(beats.size()), 32'd0);
    run_req(1'b0, 1'b0, 32'h0000_0044, 32'd0, 4'd0, st, rd);
    chk("rw_load_rdata", rd, 32'hAABB_A5E1);

    // Reset during the second refill beat aborts the burst
    @(posedge clock); #1;
    beats.delete();
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0080;
    found    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_req && mem_addr == 32'h0000_0084) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reached_beat2", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    cpu_read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run_req(1'b0, 1'b0, 32'h0000_0080, 32'd0, 4'd0, st, rd);
    chk("after_abort_stall", 32'(st), 32'd5);
    chk("after_abort_rdata", rd, 32'hA5A5_A525);
    chk("after_abort_nbeats", 32'(beats.size()), 32'd4);
    chk_beats("after_abort_rd", 1'b0, 32'h80, 0, 4);

    // Earlier lines are gone after reset: 0x44 misses again
    run_req(1'b0, 1'b0, 32'h0000_0044, 32'd0, 4'd0, st, rd);
    chk("post_rst_miss_stall", 32'(st), 32'd5);
    chk("post_rst_rdata", rd, 32'hA5A5_A5E1);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Acts as the responder to the pipeline's MEM-stage data port. It services load/store requests, stalls the pipeline on a miss, and evicts or refills lines from the next-level memory over a word-serial request/ready handshake.
- It replaces the flat data memory between the CPU MEM stage and main memory.

Parameters:
INDEX_BITS, 4, number of line-index bits; lines = 2**INDEX_BITS.
OFFSET_BITS, 2, word-in-line bits; words per line = 2**OFFSET_BITS.
ADDR_BITS, 32, byte-address width; tag = ADDR_BITS-INDEX_BITS-OFFSET_BITS-2.

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_read  input  1  load request (MEM stage)
cpu_write  input  1  store request (MEM stage)
cpu_addr  input  ADDR_BITS  byte address; bits [1:0] are ignored
cpu_wdata  input  32  store data, already lane-aligned
cpu_byte_en  input  4  store byte enables; bit i enables byte lane i
cpu_rdata  output  32  load data, valid in the cycle cpu_stall==0
cpu_stall  output  1  freeze pipeline; the request must be held stable while high
mem_req  output  1  beat request to next level
mem_we  output  1  1 = write beat, 0 = read beat
mem_addr  output  ADDR_BITS  word-aligned beat address
mem_wdata  output  32  write beat data
mem_rdata  input  32  read beat data, valid with mem_ready
mem_ready  input  1  beat complete this cycle

Behaviour:
- Address split: tag = addr[ADDR_BITS-1 : INDEX_BITS+OFFSET_BITS+2]; index = addr[INDEX_BITS+OFFSET_BITS+1 : OFFSET_BITS+2]; word = addr[OFFSET_BITS+1 : 2].
- Hit condition: valid[index] && tag match.
- Storage per line: valid bit, dirty bit, tag, 2**OFFSET_BITS data words.
- Request with cpu_read and cpu_write both high is treated as a write.
- Reset (async, active-low):
  - All valid and dirty bits are cleared; data arrays are not cleared.
  - state=IDLE, beat counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - cpu_stall=0 while no request is present.
- Reset mid-operation aborts any burst immediately: mem_req drops, and dirty data in flight is lost by design.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - No request: cpu_stall=0.
  - Read hit: cpu_rdata is combinational from the array, cpu_stall=0, zero added latency.
  - Write hit: enabled bytes update at the clock edge, dirty set, cpu_stall=0.
  - Miss: cpu_stall=1 combinationally in the same cycle.
    - Next state is WRITEBACK if the victim line is valid and dirty.
    - Otherwise next state is REFILL.
    - Beat counter is cleared.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, counter, 2'b00}.
  - mem_wdata = victim word[counter].
  - Each cycle with mem_ready=1, the counter increments.
  - On the last beat (counter==max): go to REFILL, clear counter and dirty bit.
- REFILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {request tag, index, counter, 2'b00}.
  - Each mem_ready beat writes mem_rdata into word[counter].
  - On the last beat: set valid, write tag, clear dirty, return to IDLE.
  - The held request then hits in the following cycle; that cycle drops stall and a pending store merges and sets dirty.
- cpu_stall=1 throughout WRITEBACK and REFILL.
- mem_ready=0 holds all mem_* outputs stable, with no timeout.
- mem_ready is ignored when mem_req=0.
- Counter wraps at 2**OFFSET_BITS.
- Miss penalty with mem_ready tied high:
  - Clean miss: N+1 stall cycles.
  - Dirty miss: 2N+1 stall cycles.
  - N = words per line.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined adds outputs stat_hits[31:0], stat_misses[31:0], stat_writebacks[31:0].
  - They reset to 0 and saturate at 32'hFFFFFFFF.
  - hits increments once per completed request that hit on first presentation.
  - misses increments once per miss entry from IDLE.
  - writebacks increments once per WRITEBACK entry.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Cold load 0x00000040, mem_ready always 1, memory word at addr = addr^0xA5A5A5A5:
  - 4 read beats at 0x40, 0x44, 0x48, 0x4C.
  - cpu_stall high for 5 cycles.
  - cpu_rdata=0xA5A5A5E5.
- Load 0x00000044 immediately after: no mem_req, cpu_stall=0, cpu_rdata=0xA5A5A5E1.
- Store 0x00000048, wdata 0x11223344, byte_en 4'b0011, then load 0x48:
  - No mem traffic.
  - Load returns 0xA5A53344.
- Load 0x00000448 (same index, new tag):
  - 4 write beats at 0x40..0x4C, with 0x48 carrying 0xA5A53344.
  - Then 4 read beats at 0x440..0x44C.
  - Stall for 9 cycles.
- Refill with mem_ready pulsed every 3rd cycle: mem_addr/mem_we stay stable between beats, and the stall length equals 3x the beat count plus 1.
- Assert reset during beat 2 of a refill:
  - mem_req=0 immediately.
  - Re-load of the same address misses and performs a full 4-beat refill.
